// File: rtl/vote_input_ctrl.sv
// Input front-end for the voting tally: synchronises and debounces four candidate
// buttons, allows one vote per press-and-release, and routes buttons to display select in mode 1.
module vote_input_ctrl #(
   parameter int DEBOUNCE_CYC = 10,
   parameter int HOLDOFF_CYC  = 4,
   parameter int TOTAL_W      = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               mode,
   input  logic               button1,
   input  logic               button2,
   input  logic               button3,
   input  logic               button4,
   output logic               vote_valid,
   output logic [1:0]         vote_idx,
   output logic               reject_pulse,
   output logic               disp_valid,
   output logic [1:0]         disp_sel,
   output logic               busy,
   output logic [TOTAL_W-1:0] total_votes
);

   localparam int CNT_MAX = (DEBOUNCE_CYC > HOLDOFF_CYC) ? DEBOUNCE_CYC : HOLDOFF_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE         = 3'd0,
      S_DEBOUNCE     = 3'd1,
      S_ACCEPT       = 3'd2,
      S_REJECT       = 3'd3,
      S_WAIT_RELEASE = 3'd4,
      S_HOLDOFF      = 3'd5,
      S_DISPLAY      = 3'd6
   } state_t;

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] encode(input logic [3:0] v);
      logic [1:0] idx;
      case (v)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   logic [4:0]         r_sync1;
   logic [4:0]         r_sync2;
   logic               w_mode_s;
   logic [3:0]         w_btn_s;
   state_t             r_state;
   state_t             w_state_nxt;
   logic [3:0]         r_snap;
   logic [3:0]         w_snap_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_vote_valid;
   logic [1:0]         r_vote_idx;
   logic               r_reject;
   logic               r_disp_valid;
   logic [1:0]         r_disp_sel;
   logic               r_busy;
   logic [TOTAL_W-1:0] r_total;

   assign w_mode_s = r_sync2[4];
   assign w_btn_s  = r_sync2[3:0];

   // Two-flop synchroniser for mode and the raw buttons.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync1 <= 5'd0;
         r_sync2 <= 5'd0;
      end else begin
         r_sync1 <= {mode, button4, button3, button2, button1};
         r_sync2 <= r_sync1;
      end
   end

   // State, snapshot and shared cycle counter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_snap  <= 4'd0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_snap  <= w_snap_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic; the counter is shared by debounce and holdoff phases.
   always_comb begin
      w_state_nxt = r_state;
      w_snap_nxt  = r_snap;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_mode_s) begin
               w_state_nxt = S_DISPLAY;
            end else if (w_btn_s != 4'd0) begin
               w_state_nxt = S_DEBOUNCE;
               w_snap_nxt  = w_btn_s;
               w_cnt_nxt   = CNT_W'(1);
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_DEBOUNCE: begin
            if (w_mode_s) begin
               w_state_nxt = S_DISPLAY;
            end else if (w_btn_s == 4'd0) begin
               w_state_nxt = S_IDLE;
            end else if (w_btn_s != r_snap) begin
               w_snap_nxt = w_btn_s;
               w_cnt_nxt  = CNT_W'(1);
            end else if (r_cnt < CNT_W'(DEBOUNCE_CYC)) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end else begin
               w_state_nxt = is_onehot(r_snap) ? S_ACCEPT : S_REJECT;
            end
         end
         S_ACCEPT: w_state_nxt = S_WAIT_RELEASE;
         S_REJECT: w_state_nxt = S_WAIT_RELEASE;
         S_WAIT_RELEASE: begin
            if (w_btn_s == 4'd0) begin
               w_state_nxt = S_HOLDOFF;
               w_cnt_nxt   = CNT_W'(1);
            end else begin
               w_state_nxt = S_WAIT_RELEASE;
            end
         end
         S_HOLDOFF: begin
            if (w_btn_s != 4'd0) begin
               w_state_nxt = S_WAIT_RELEASE;
            end else if (r_cnt == CNT_W'(HOLDOFF_CYC)) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_DISPLAY: begin
            // Leaving display goes through release so a held button never votes.
            if (!w_mode_s) begin
               w_state_nxt = S_WAIT_RELEASE;
            end else begin
               w_state_nxt = S_DISPLAY;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Registered outputs, decoded from the next state so they align with it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_vote_valid <= 1'b0;
         r_vote_idx   <= 2'd0;
         r_reject     <= 1'b0;
         r_disp_valid <= 1'b0;
         r_disp_sel   <= 2'd0;
         r_busy       <= 1'b0;
         r_total      <= '0;
      end else begin
         r_vote_valid <= (w_state_nxt == S_ACCEPT);
         r_reject     <= (w_state_nxt == S_REJECT);
         r_disp_valid <= (w_state_nxt == S_DISPLAY);
         r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DISPLAY);
         if (w_state_nxt == S_ACCEPT) begin
            r_vote_idx <= encode(w_snap_nxt);
            if (r_total != {TOTAL_W{1'b1}}) begin
               r_total <= r_total + TOTAL_W'(1);
            end else begin
               r_total <= r_total;
            end
         end else begin
            r_vote_idx <= r_vote_idx;
            r_total    <= r_total;
         end
         if ((r_state == S_DISPLAY) && is_onehot(w_btn_s)) begin
            r_disp_sel <= encode(w_btn_s);
         end else begin
            r_disp_sel <= r_disp_sel;
         end
      end
   end

   assign vote_valid   = r_vote_valid;
   assign vote_idx     = r_vote_idx;
   assign reject_pulse = r_reject;
   assign disp_valid   = r_disp_valid;
   assign disp_sel     = r_disp_sel;
   assign busy         = r_busy;
   assign total_votes  = r_total;

endmodule

// File: tb/tb_vote_input_ctrl.sv
// Self-checking bench: two instances (8-bit and 2-bit totals) share stimulus and are
// compared each cycle against a behavioural model, plus table rows and hand sequences.
module tb_vote_input_ctrl;

   localparam int D = 10;
   localparam int H = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       mode  = 1'b0;
   logic [3:0] btn   = 4'd0;

   logic       vv_a, rj_a, dv_a, bs_a;
   logic [1:0] vi_a, ds_a;
   logic [7:0] tot_a;
   logic       vv_b, rj_b, dv_b, bs_b;
   logic [1:0] vi_b, ds_b;
   logic [1:0] tot_b;

   int n_err = 0;
   int n_checks = 0;
   int obs_votes = 0;
   int obs_rejs = 0;

   always #5 clock = ~clock;

   vote_input_ctrl #(.DEBOUNCE_CYC(D), .HOLDOFF_CYC(H), .TOTAL_W(8)) dut_a (
      .clock(clock), .reset(reset), .mode(mode),
      .button1(btn[0]), .button2(btn[1]), .button3(btn[2]), .button4(btn[3]),
      .vote_valid(vv_a), .vote_idx(vi_a), .reject_pulse(rj_a), .disp_valid(dv_a),
      .disp_sel(ds_a), .busy(bs_a), .total_votes(tot_a));

   vote_input_ctrl #(.DEBOUNCE_CYC(D), .HOLDOFF_CYC(H), .TOTAL_W(2)) dut_b (
      .clock(clock), .reset(reset), .mode(mode),
      .button1(btn[0]), .button2(btn[1]), .button3(btn[2]), .button4(btn[3]),
      .vote_valid(vv_b), .vote_idx(vi_b), .reject_pulse(rj_b), .disp_valid(dv_b),
      .disp_sel(ds_b), .busy(bs_b), .total_votes(tot_b));

   // Behavioural model: press lifecycle tracked as flags and plain counters.
   logic [3:0] h1, h2;
   logic       hm1, hm2;
   bit         showing, locked;
   int         cool, run, emit;
   logic [3:0] pat;
   int         e_vv, e_rj, e_idx, e_sel, e_tot_a, e_tot_b;

   function automatic bit onehot(input logic [3:0] v);
      return $countones(v) == 1;
   endfunction

   function automatic int idx_of(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_step();
      logic [3:0] s;
      logic       ms;
      if (reset) begin
         h1 = 4'd0; h2 = 4'd0; hm1 = 1'b0; hm2 = 1'b0;
         showing = 1'b0; locked = 1'b0; cool = 0; run = 0; emit = 0; pat = 4'd0;
         e_vv = 0; e_rj = 0; e_idx = 0; e_sel = 0; e_tot_a = 0; e_tot_b = 0;
         return;
      end
      s = h2; ms = hm2;
      e_vv = 0; e_rj = 0;
      if (emit != 0) begin
         emit = 0; locked = 1'b1;
      end else if (showing) begin
         if (onehot(s)) e_sel = idx_of(s);
         if (!ms) begin showing = 1'b0; locked = 1'b1; end
      end else if (locked) begin
         if (s == 4'd0) begin locked = 1'b0; cool = 1; end
      end else if (cool > 0) begin
         if (s != 4'd0) begin cool = 0; locked = 1'b1; end
         else if (cool == H) cool = 0;
         else cool++;
      end else if (run > 0) begin
         if (ms) begin run = 0; showing = 1'b1; end
         else if (s == 4'd0) run = 0;
         else if (s != pat) begin pat = s; run = 1; end
         else if (run < D) run++;
         else begin
            run = 0;
            if (onehot(pat)) begin
               emit = 1; e_vv = 1; e_idx = idx_of(pat);
               if (e_tot_a < 255) e_tot_a++;
               if (e_tot_b < 3) e_tot_b++;
            end else begin
               emit = 2; e_rj = 1;
            end
         end
      end else begin
         if (ms) showing = 1'b1;
         else if (s != 4'd0) begin run = 1; pat = s; end
      end
      h2 = h1; h1 = btn; hm2 = hm1; hm1 = mode;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      int e_busy;
      e_busy = (emit != 0 || locked || cool > 0 || run > 0) ? 1 : 0;
      chk("vote_valid_a", vv_a, e_vv);     chk("vote_valid_b", vv_b, e_vv);
      chk("vote_idx_a", vi_a, e_idx);      chk("vote_idx_b", vi_b, e_idx);
      chk("reject_a", rj_a, e_rj);         chk("reject_b", rj_b, e_rj);
      chk("disp_valid_a", dv_a, showing);  chk("disp_valid_b", dv_b, showing);
      chk("disp_sel_a", ds_a, e_sel);      chk("disp_sel_b", ds_b, e_sel);
      chk("busy_a", bs_a, e_busy);         chk("busy_b", bs_b, e_busy);
      chk("total_a", tot_a, e_tot_a);      chk("total_b", tot_b, e_tot_b);
      obs_votes += vv_a;
      obs_rejs  += rj_a;
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      check_all();
   endtask

   typedef struct {
      logic       m;
      logic [3:0] b;
      int         cyc;
      int         votes;
      int         rejs;
      int         tot;
      int         sel;
   } row_t;

   row_t rows[$];

   initial begin
      int t;
      int dur;
      int pick;
      rows.push_back('{1'b0, 4'b0001,  1, 0, 0, -1, -1});
      rows.push_back('{1'b0, 4'b0000,  1, 0, 0, -1, -1});
      rows.push_back('{1'b0, 4'b0001, 20, 1, 0,  1, -1});
      rows.push_back('{1'b0, 4'b0000, 10, 0, 0,  1, -1});
      rows.push_back('{1'b0, 4'b0010, 20, 1, 0,  2, -1});
      rows.push_back('{1'b0, 4'b0000, 25, 0, 0,  2, -1});
      rows.push_back('{1'b0, 4'b0010, 20, 1, 0,  3, -1});
      rows.push_back('{1'b0, 4'b0000, 10, 0, 0,  3, -1});
      rows.push_back('{1'b0, 4'b0110, 20, 0, 1,  3, -1});
      rows.push_back('{1'b0, 4'b0100, 20, 0, 0,  3, -1});
      rows.push_back('{1'b0, 4'b0000, 10, 0, 0,  3, -1});
      rows.push_back('{1'b1, 4'b0000,  4, 0, 0,  3, -1});
      rows.push_back('{1'b1, 4'b0100,  5, 0, 0,  3,  2});
      rows.push_back('{1'b0, 4'b0100, 10, 0, 0,  3,  2});
      rows.push_back('{1'b0, 4'b0000, 10, 0, 0,  3,  2});
      rows.push_back('{1'b0, 4'b0100, 15, 1, 0,  4,  2});
      rows.push_back('{1'b0, 4'b0000, 10, 0, 0,  4,  2});

      reset = 1'b1;
      repeat (10) tick();
      reset = 1'b0;
      tick();
      chk("rst_vote_valid", vv_a, 0);
      chk("rst_reject", rj_a, 0);
      chk("rst_disp_valid", dv_a, 0);
      chk("rst_busy", bs_a, 0);
      chk("rst_total", tot_a, 0);
      chk("rst_disp_sel", ds_a, 0);

      foreach (rows[r]) begin
         mode = rows[r].m;
         btn  = rows[r].b;
         obs_votes = 0;
         obs_rejs  = 0;
         repeat (rows[r].cyc) tick();
         chk($sformatf("row%0d_votes", r), obs_votes, rows[r].votes);
         chk($sformatf("row%0d_rejects", r), obs_rejs, rows[r].rejs);
         if (rows[r].tot >= 0) chk($sformatf("row%0d_total", r), tot_a, rows[r].tot);
         if (rows[r].sel >= 0) chk($sformatf("row%0d_disp_sel", r), ds_a, rows[r].sel);
      end

      // Latency: captured at tick 1, pulse visible after tick 1+D+2.
      btn = 4'b1000;
      for (t = 1; t <= 16; t++) begin
         tick();
         chk($sformatf("latency_t%0d", t), vv_a, (t == D + 3) ? 1 : 0);
      end
      chk("latency_idx", vi_a, 3);
      btn = 4'b0000;
      repeat (10) tick();

      // Saturation of the 2-bit instance over five more clean votes.
      obs_votes = 0;
      for (int v = 0; v < 5; v++) begin
         btn = 4'b0001 << (v % 4);
         repeat (15) tick();
         btn = 4'b0000;
         repeat (10) tick();
      end
      chk("sat_pulses", obs_votes, 5);
      chk("sat_total_b", tot_b, 3);
      chk("sat_total_a", tot_a, 10);

      // Reset in the middle of debounce discards the pending press.
      obs_votes = 0;
      btn = 4'b0010;
      repeat (6) tick();
      chk("mid_debounce_busy", bs_a, 1);
      reset = 1'b1;
      #1;
      chk("async_rst_total_a", tot_a, 0);
      chk("async_rst_total_b", tot_b, 0);
      chk("async_rst_busy", bs_a, 0);
      repeat (3) tick();
      btn = 4'b0000;
      reset = 1'b0;
      repeat (20) tick();
      chk("post_rst_votes", obs_votes, 0);
      chk("post_rst_total", tot_a, 0);

      // Randomised segments against the model.
      for (int seg = 0; seg < 120; seg++) begin
         mode = ($urandom_range(0, 7) == 0);
         pick = $urandom_range(0, 9);
         if (pick < 4) btn = 4'd0;
         else if (pick < 8) btn = 4'b0001 << $urandom_range(0, 3);
         else btn = 4'($urandom_range(0, 15));
         dur = $urandom_range(1, 25);
         repeat (dur) tick();
      end

      mode = 1'b0;
      btn  = 4'd0;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      chk("final_total", tot_a, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
